// File: rtl/param_microcode_controller_if.sv
// Control/status bundle between the microcode controller and the CPU datapath.
// The controller side is the master; the datapath (IR, flags, step switch) is the slave.
interface param_microcode_controller_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic [3:0]        i_opcode;
    logic [ADDR_W-1:0] i_arg;
    logic              i_flag_z;
    logic              i_flag_c;
    logic              i_step_en;
    logic              i_step;

    logic              o_pc_read_n;
    logic              o_pc_write_n;
    logic              o_pc_inc_n;
    logic              o_mar_write_n;
    logic              o_mem_read_n;
    logic              o_mem_write_n;
    logic              o_ir_write_n;
    logic              o_a_read_n;
    logic              o_a_write_n;
    logic              o_b_write_n;
    logic              o_alu_read_n;
    logic              o_alu_sub;
    logic              o_flags_write_n;
    logic              o_out_write_n;
    logic              o_halt;
    logic              o_instr_done;
    logic [CNT_W-1:0]  o_icount;

    modport master (
        input  i_opcode, i_arg, i_flag_z, i_flag_c, i_step_en, i_step,
        output o_pc_read_n, o_pc_write_n, o_pc_inc_n, o_mar_write_n, o_mem_read_n,
               o_mem_write_n, o_ir_write_n, o_a_read_n, o_a_write_n, o_b_write_n,
               o_alu_read_n, o_alu_sub, o_flags_write_n, o_out_write_n,
               o_halt, o_instr_done, o_icount
    );

    modport slave (
        output i_opcode, i_arg, i_flag_z, i_flag_c, i_step_en, i_step,
        input  o_pc_read_n, o_pc_write_n, o_pc_inc_n, o_mar_write_n, o_mem_read_n,
               o_mem_write_n, o_ir_write_n, o_a_read_n, o_a_write_n, o_b_write_n,
               o_alu_read_n, o_alu_sub, o_flags_write_n, o_out_write_n,
               o_halt, o_instr_done, o_icount
    );
endinterface

// File: rtl/param_microcode_controller.sv
// Parametrised fetch/decode/execute sequencer for the bus-based CPU.
// Every control output is registered from the state being entered, so strobes line up with their state.
module param_microcode_controller #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    param_microcode_controller_if.master  ctl,
    inout  wire  [DATA_W-1:0]             io_bus
);
    typedef enum logic [2:0] {
        S_FETCH0, S_FETCH1, S_DECODE, S_EXEC1, S_EXEC2, S_WAIT, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_LDA, OP_LDAI, OP_LDB, OP_LDBI, OP_LDO, OP_LDOI, OP_MOVA,
        OP_ADD, OP_SUB, OP_STA, OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_HLT
    } opcode_t;

    typedef struct packed {
        logic pc_read, pc_write, pc_inc, mar_write, mem_read, mem_write, ir_write;
        logic a_read, a_write, b_write, alu_read, alu_sub, flags_write, out_write;
    } strobes_t;

    state_t            state_q, nxt_state;
    strobes_t          stb_q, nxt_stb;
    logic              primed_q;
    logic              drive_q, nxt_drive;
    logic [DATA_W-1:0] bus_q;
    logic [3:0]        op_q, op_cur;
    logic              halt_q, done_q, nxt_done, retire;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] arg;

    assign arg    = ctl.i_arg;
    // The opcode is read live while decoding and from the latched copy afterwards.
    assign op_cur = (state_q == S_DECODE) ? ctl.i_opcode : op_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        nxt_state = state_q;
        retire    = 1'b0;
        if (!primed_q) begin
            nxt_state = S_FETCH0;  // first edge after reset loads the FETCH0 strobes
        end else begin
            unique case (state_q)
                S_FETCH0: nxt_state = S_FETCH1;
                S_FETCH1: nxt_state = S_DECODE;
                S_DECODE: nxt_state = (ctl.i_opcode == OP_HLT) ? S_HALT : S_EXEC1;
                S_EXEC1: begin
                    if (op_q inside {OP_LDA, OP_LDB, OP_LDO, OP_STA}) nxt_state = S_EXEC2;
                    else retire = 1'b1;
                end
                S_EXEC2:  retire = 1'b1;
                S_WAIT:   if (ctl.i_step || !ctl.i_step_en) nxt_state = S_FETCH0;
                S_HALT:   nxt_state = S_HALT;
                default:  nxt_state = S_FETCH0;
            endcase
        end
        if (retire) nxt_state = ctl.i_step_en ? S_WAIT : S_FETCH0;

        nxt_stb   = '0;
        nxt_drive = 1'b0;
        unique case (nxt_state)
            S_FETCH0: begin
                nxt_stb.pc_read   = 1'b1;
                nxt_stb.mar_write = 1'b1;
            end
            S_FETCH1: begin
                nxt_stb.mem_read = 1'b1;
                nxt_stb.ir_write = 1'b1;
                nxt_stb.pc_inc   = 1'b1;
            end
            S_EXEC1: begin
                // Jump conditions come from the flag register as it stands when EXEC1 is entered.
                unique case (op_cur)
                    OP_LDA, OP_LDB, OP_LDO, OP_STA: begin
                        nxt_drive = 1'b1; nxt_stb.mar_write = 1'b1;
                    end
                    OP_LDAI: begin nxt_drive = 1'b1; nxt_stb.a_write   = 1'b1; end
                    OP_LDBI: begin nxt_drive = 1'b1; nxt_stb.b_write   = 1'b1; end
                    OP_LDOI: begin nxt_drive = 1'b1; nxt_stb.out_write = 1'b1; end
                    OP_MOVA: begin nxt_stb.a_read = 1'b1; nxt_stb.out_write = 1'b1; end
                    OP_ADD, OP_SUB: begin
                        nxt_stb.alu_read    = 1'b1;
                        nxt_stb.a_write     = 1'b1;
                        nxt_stb.flags_write = 1'b1;
                        nxt_stb.alu_sub     = (op_cur == OP_SUB);
                    end
                    OP_JMP, OP_JZ, OP_JNZ, OP_JC: begin
                        if ((op_cur == OP_JMP) ||
                            (op_cur == OP_JZ  &&  ctl.i_flag_z) ||
                            (op_cur == OP_JNZ && !ctl.i_flag_z) ||
                            (op_cur == OP_JC  &&  ctl.i_flag_c)) begin
                            nxt_drive = 1'b1; nxt_stb.pc_write = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                unique case (op_cur)
                    OP_LDA: begin nxt_stb.mem_read = 1'b1; nxt_stb.a_write   = 1'b1; end
                    OP_LDB: begin nxt_stb.mem_read = 1'b1; nxt_stb.b_write   = 1'b1; end
                    OP_LDO: begin nxt_stb.mem_read = 1'b1; nxt_stb.out_write = 1'b1; end
                    OP_STA: begin nxt_stb.a_read   = 1'b1; nxt_stb.mem_write = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase

        // HLT retires on the edge that enters S_HALT; staying there never pulses again.
        nxt_done = retire || (state_q == S_DECODE && nxt_state == S_HALT);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_FETCH0;
            primed_q <= 1'b0;
            stb_q    <= '0;
            drive_q  <= 1'b0;
            bus_q    <= '0;
            op_q     <= OP_NOP;
            halt_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= nxt_state;
            primed_q <= 1'b1;
            stb_q    <= nxt_stb;
            drive_q  <= nxt_drive;
            bus_q    <= DATA_W'(arg);
            halt_q   <= (nxt_state == S_HALT);
            done_q   <= nxt_done;
            if (state_q == S_DECODE) op_q <= ctl.i_opcode;
            if (nxt_done) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign io_bus = drive_q ? bus_q : {DATA_W{1'bz}};

    assign ctl.o_pc_read_n     = ~stb_q.pc_read;
    assign ctl.o_pc_write_n    = ~stb_q.pc_write;
    assign ctl.o_pc_inc_n      = ~stb_q.pc_inc;
    assign ctl.o_mar_write_n   = ~stb_q.mar_write;
    assign ctl.o_mem_read_n    = ~stb_q.mem_read;
    assign ctl.o_mem_write_n   = ~stb_q.mem_write;
    assign ctl.o_ir_write_n    = ~stb_q.ir_write;
    assign ctl.o_a_read_n      = ~stb_q.a_read;
    assign ctl.o_a_write_n     = ~stb_q.a_write;
    assign ctl.o_b_write_n     = ~stb_q.b_write;
    assign ctl.o_alu_read_n    = ~stb_q.alu_read;
    assign ctl.o_alu_sub       =  stb_q.alu_sub;
    assign ctl.o_flags_write_n = ~stb_q.flags_write;
    assign ctl.o_out_write_n   = ~stb_q.out_write;
    assign ctl.o_halt          = halt_q;
    assign ctl.o_instr_done    = done_q;
    assign ctl.o_icount        = cnt_q;
endmodule

// File: tb/tb_param_microcode_controller.sv
// Bench for param_microcode_controller: per-instruction vector table feeding a per-cycle scoreboard,
// plus step-mode, halt, mid-instruction reset, counter wrap and wide-bus instances.
module tb_param_microcode_controller;
    // Active-high view of the outputs, one bit per signal.
    localparam logic [15:0] PCR = 16'h0001, PCW = 16'h0002, PCI = 16'h0004, MARW = 16'h0008;
    localparam logic [15:0] MR  = 16'h0010, MW  = 16'h0020, IRW = 16'h0040, AR   = 16'h0080;
    localparam logic [15:0] AW  = 16'h0100, BW  = 16'h0200, ALR = 16'h0400, SUBF = 16'h0800;
    localparam logic [15:0] FW  = 16'h1000, OW  = 16'h2000, HLT = 16'h4000, DONE = 16'h8000;
    localparam logic [15:0] F0  = PCR | MARW;
    localparam logic [15:0] F1  = MR | IRW | PCI;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  arg;
        logic        z;
        logic        c;
        logic [15:0] e1;
        logic [15:0] e2;
        int          ncyc;
        bit          drv;
    } vec_t;

    typedef struct {
        logic [15:0] mask;
        bit          bus_chk;
        logic [7:0]  bus;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst2 = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    logic [15:0] exp_cnt = '0;
    bit   aux_done = 1'b0;
    vec_t tbl[$];
    exp_t sb[$];

    param_microcode_controller_if #(.ADDR_W(4), .CNT_W(16)) cif ();
    param_microcode_controller_if #(.ADDR_W(4), .CNT_W(4))  cif2 ();
    param_microcode_controller_if #(.ADDR_W(8), .CNT_W(16)) cif3 ();
    wire [7:0]  bus;
    wire [7:0]  bus2;
    wire [15:0] bus3;

    param_microcode_controller #(.DATA_W(8), .ADDR_W(4), .CNT_W(16)) dut (
        .i_clk(clk), .i_reset(rst), .ctl(cif), .io_bus(bus));
    param_microcode_controller #(.DATA_W(8), .ADDR_W(4), .CNT_W(4)) dut_wrap (
        .i_clk(clk), .i_reset(rst2), .ctl(cif2), .io_bus(bus2));
    param_microcode_controller #(.DATA_W(16), .ADDR_W(8), .CNT_W(16)) dut_wide (
        .i_clk(clk), .i_reset(rst2), .ctl(cif3), .io_bus(bus3));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s (cycle %0d): got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] act_mask();
        return {cif.o_instr_done, cif.o_halt, ~cif.o_out_write_n, ~cif.o_flags_write_n,
                cif.o_alu_sub, ~cif.o_alu_read_n, ~cif.o_b_write_n, ~cif.o_a_write_n,
                ~cif.o_a_read_n, ~cif.o_ir_write_n, ~cif.o_mem_write_n, ~cif.o_mem_read_n,
                ~cif.o_mar_write_n, ~cif.o_pc_inc_n, ~cif.o_pc_write_n, ~cif.o_pc_read_n};
    endfunction

    task automatic push(input logic [15:0] m, input bit chk, input logic [7:0] b);
        exp_t e;
        if (m[15]) exp_cnt = exp_cnt + 16'd1;
        e.mask = m; e.bus_chk = chk; e.bus = b; e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(negedge clk);
            cyc++;
            e = sb.pop_front();
            cif.i_step = 1'b0;
            check("strobes", act_mask(), e.mask);
            check("icount", cif.o_icount, e.cnt);
            if (e.bus_chk) check("bus", bus, e.bus);
        end
    endtask

    task automatic run_instr(input vec_t v, input bit done_first);
        cif.i_opcode = v.op;
        cif.i_arg    = v.arg;
        cif.i_flag_z = v.z;
        cif.i_flag_c = v.c;
        push(done_first ? (F0 | DONE) : F0, 1'b0, 8'h00);
        push(F1, 1'b0, 8'h00);
        push(16'h0000, 1'b0, 8'h00);
        push(v.e1, v.drv, 8'(v.arg));
        if (v.ncyc == 5) push(v.e2, 1'b0, 8'h00);
        drain();
    endtask

    // Counter wrap (CNT_W=4, all NOPs) and wide bus (DATA_W=16, LDAI 0xA5) run from their own reset.
    initial begin
        cif2.i_opcode = 4'h0; cif2.i_arg = 4'h0; cif2.i_flag_z = 1'b0; cif2.i_flag_c = 1'b0;
        cif2.i_step_en = 1'b0; cif2.i_step = 1'b0;
        cif3.i_opcode = 4'h2; cif3.i_arg = 8'hA5; cif3.i_flag_z = 1'b0; cif3.i_flag_c = 1'b0;
        cif3.i_step_en = 1'b0; cif3.i_step = 1'b0;
        @(negedge rst2);
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (k == 61) check("wrap_icount_15", cif2.o_icount, 4'd15);
            if (k == 65) begin
                check("wrap_icount_0", cif2.o_icount, 4'd0);
                check("wrap_done", cif2.o_instr_done, 1'b1);
            end
            if (k == 3) check("wide_decode_awrite", cif3.o_a_write_n, 1'b1);
            if (k == 4 || k == 8) begin
                check("wide_bus", bus3, 16'h00A5);
                check("wide_awrite", cif3.o_a_write_n, 1'b0);
            end
        end
        aux_done = 1'b1;
    end

    initial begin
        tbl.push_back(vec_t'{4'h2, 4'h5, 1'b0, 1'b0, AW,              16'h0,   4, 1'b1}); // LDAI 5
        tbl.push_back(vec_t'{4'h8, 4'h0, 1'b0, 1'b0, ALR | AW | FW,   16'h0,   4, 1'b0}); // ADD
        tbl.push_back(vec_t'{4'h2, 4'h9, 1'b0, 1'b0, AW,              16'h0,   4, 1'b1}); // LDAI 9
        tbl.push_back(vec_t'{4'hA, 4'hC, 1'b0, 1'b0, MARW,            AR | MW, 5, 1'b1}); // STA C
        tbl.push_back(vec_t'{4'h9, 4'h0, 1'b0, 1'b0, ALR|SUBF|AW|FW,  16'h0,   4, 1'b0}); // SUB
        tbl.push_back(vec_t'{4'h1, 4'h6, 1'b0, 1'b0, MARW,            MR | AW, 5, 1'b1}); // LDA 6
        tbl.push_back(vec_t'{4'h3, 4'h7, 1'b0, 1'b0, MARW,            MR | BW, 5, 1'b1}); // LDB 7
        tbl.push_back(vec_t'{4'h5, 4'h8, 1'b0, 1'b0, MARW,            MR | OW, 5, 1'b1}); // LDO 8
        tbl.push_back(vec_t'{4'h4, 4'h3, 1'b0, 1'b0, BW,              16'h0,   4, 1'b1}); // LDBI 3
        tbl.push_back(vec_t'{4'h7, 4'h0, 1'b0, 1'b0, AR | OW,         16'h0,   4, 1'b0}); // MOVA
        tbl.push_back(vec_t'{4'h0, 4'h0, 1'b0, 1'b0, 16'h0,           16'h0,   4, 1'b0}); // NOP
        tbl.push_back(vec_t'{4'hB, 4'h2, 1'b0, 1'b0, PCW,             16'h0,   4, 1'b1}); // JMP 2
        tbl.push_back(vec_t'{4'hC, 4'h2, 1'b0, 1'b0, 16'h0,           16'h0,   4, 1'b0}); // JZ z=0
        tbl.push_back(vec_t'{4'hC, 4'h2, 1'b1, 1'b0, PCW,             16'h0,   4, 1'b1}); // JZ z=1
        tbl.push_back(vec_t'{4'hC, 4'h2, 1'b0, 1'b1, 16'h0,           16'h0,   4, 1'b0}); // JZ z=0 c=1
        tbl.push_back(vec_t'{4'hD, 4'h3, 1'b0, 1'b0, PCW,             16'h0,   4, 1'b1}); // JNZ z=0
        tbl.push_back(vec_t'{4'hD, 4'h3, 1'b1, 1'b0, 16'h0,           16'h0,   4, 1'b0}); // JNZ z=1
        tbl.push_back(vec_t'{4'hE, 4'h4, 1'b0, 1'b0, 16'h0,           16'h0,   4, 1'b0}); // JC c=0
        tbl.push_back(vec_t'{4'hE, 4'h4, 1'b0, 1'b1, PCW,             16'h0,   4, 1'b1}); // JC c=1
        tbl.push_back(vec_t'{4'hE, 4'h4, 1'b1, 1'b0, 16'h0,           16'h0,   4, 1'b0}); // JC z=1 c=0
        tbl.push_back(vec_t'{4'h6, 4'h7, 1'b0, 1'b0, OW,              16'h0,   4, 1'b1}); // LDOI 7

        cif.i_opcode = 4'h0; cif.i_arg = 4'h0; cif.i_flag_z = 1'b0; cif.i_flag_c = 1'b0;
        cif.i_step_en = 1'b0; cif.i_step = 1'b0;
        #2;
        rst = 1'b1; rst2 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_strobes", act_mask(), 16'h0000);
        check("reset_icount", cif.o_icount, 16'd0);
        rst = 1'b0; rst2 = 1'b0;
        exp_cnt = '0;

        foreach (tbl[i]) run_instr(tbl[i], i > 0);

        // Single-step: the LDOI 7 above retires into S_WAIT and is held there.
        cif.i_step_en = 1'b1;
        push(DONE, 1'b0, 8'h00);
        repeat (9) push(16'h0000, 1'b0, 8'h00);
        drain();
        cif.i_step = 1'b1;
        run_instr(tbl[8], 1'b0);
        push(DONE, 1'b0, 8'h00);
        repeat (3) push(16'h0000, 1'b0, 8'h00);
        drain();

        // Leaving step mode releases S_WAIT; then reset lands in S_EXEC2 of LDA.
        cif.i_step_en = 1'b0;
        run_instr(tbl[5], 1'b0);
        rst = 1'b1;
        #1;
        check("abort_strobes", act_mask(), 16'h0000);
        check("abort_icount", cif.o_icount, 16'd0);
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        run_instr(tbl[0], 1'b0);

        // HLT retires once and then holds, ignoring step requests.
        cif.i_opcode = 4'hF;
        push(F0 | DONE, 1'b0, 8'h00);
        push(F1, 1'b0, 8'h00);
        push(16'h0000, 1'b0, 8'h00);
        push(DONE | HLT, 1'b0, 8'h00);
        drain();
        cif.i_step_en = 1'b1;
        cif.i_step = 1'b1;
        repeat (6) push(HLT, 1'b0, 8'h00);
        drain();

        for (int k = 0; k < 200 && !aux_done; k++) @(negedge clk);
        check("aux_finished", aux_done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
